// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//   Control stage in front of a combinational add/sub/complement datapath.
//   A request (opcode + operands) is taken over a valid/ready handshake and
//   its operands are registered onto alu_*. After SETTLE cycles the datapath
//   result and flags are captured and held for a downstream valid/ready
//   consumer. An accumulator holds the last legal result so that chained
//   operations can use it as the A operand.
//
// Parameters
//   WIDTH   operand/result width
//   SETTLE  cycles alu_* are held before capture (>= 1)
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               request handshake
//   in_op, in_use_acc, in_a, in_b   request: opcode, A-from-accumulator, operands
//   alu_a, alu_b, alu_op            registered operands/opcode to the datapath
//   alu_res, alu_cout               datapath result and carry/borrow
//   out_valid/out_ready             result handshake
//   out_result, out_carry,
//   out_zero, out_err               captured result and flags
//   out_ovf                         signed overflow (only with ALU_SEQ_OVF_EN)
//
// Build option
//   ALU_SEQ_OVF_EN  adds the out_ovf port and its overflow logic.
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int WIDTH  = 5,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_use_acc,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_err
`ifdef ALU_SEQ_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_NEG  = 3'b011;
  localparam logic [2:0] OP_PASS = 3'b100;

  localparam int               CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [2:0]       alu_op_q;
  logic             valid_q, carry_q, zero_q, err_q;
  logic [WIDTH-1:0] res_q;

  logic             accept;
  logic             settled;
  logic [WIDTH-1:0] res_d;
  logic             carry_d, err_d;

`ifdef ALU_SEQ_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow from operand and result sign bits; subtraction flips b's sign.
  function automatic logic ovf_f(input logic [2:0] op, input logic am, input logic bm,
                                 input logic rm);
    case (op)
      OP_ADD:  return (am == bm) && (rm != am);
      OP_SUB:  return (am != bm) && (rm != am);
      default: return 1'b0;
    endcase
  endfunction

  assign ovf_d   = ovf_f(alu_op_q, alu_a_q[WIDTH-1], alu_b_q[WIDTH-1], alu_res[WIDTH-1]);
  assign out_ovf = ovf_q;
`endif

  assign in_ready = (state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready);
  assign accept   = in_valid & in_ready;
  assign settled  = (state_q == S_BUSY) && (cnt_q == CNT_LAST);

  // Result/flag values presented for capture; CLR and illegal opcodes force 0.
  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    err_d   = (alu_op_q[2:1] == 2'b11);
    case (alu_op_q)
      OP_ADD, OP_SUB: begin
        res_d   = alu_res;
        carry_d = alu_cout;
      end
      OP_NOT, OP_NEG, OP_PASS: res_d = alu_res;
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      valid_q  <= 1'b0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      // Operands only change on acceptance, so alu_* stay quiet outside BUSY.
      if (accept) begin
        alu_a_q  <= in_use_acc ? acc_q : in_a;
        alu_b_q  <= in_b;
        alu_op_q <= in_op;
        cnt_q    <= '0;
      end

      case (state_q)
        S_IDLE: begin
          if (accept) state_q <= S_BUSY;
        end
        S_BUSY: begin
          if (settled) begin
            valid_q <= 1'b1;
            res_q   <= res_d;
            carry_q <= carry_d;
            zero_q  <= (res_d == '0);
            err_q   <= err_d;
`ifdef ALU_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
            // Illegal opcodes leave the accumulator untouched.
            if (!err_d) acc_q <= res_d;
            state_q <= S_HOLD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= accept ? S_BUSY : S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign out_valid  = valid_q;
  assign out_result = res_q;
  assign out_carry  = carry_q;
  assign out_zero   = zero_q;
  assign out_err    = err_q;

endmodule
